svm_batch_driver: RTL and testbench

- Initiator/collector for the hw_svm classifier stream interface.
- Holds a host-loaded buffer of signed 32-bit feature words and streams them to the classifier's test/test_valid/test_ready port, FEATURES words per vector.
- After each vector, waits for one label on label/label_valid/label_ready and packs the results into a bit vector with a positive count.
- Sits between the host/control logic and hw_svm, replacing hand-driven stimulus.

---
 rtl/svm_batch_driver.sv | 193 +++++++++++++++++++
 tb/tb_svm_batch_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/svm_batch_driver.sv
// Batch initiator/collector for the hw_svm stream port: streams buffered feature
// words FEATURES per vector, collects one label per vector, flags label timeouts.
module svm_batch_driver #(
  parameter  int FEATURES    = 1,
  parameter  int MAX_VECTORS = 16,
  parameter  int TIMEOUT     = 1024,
  localparam int DEPTH       = FEATURES * MAX_VECTORS,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW          = $clog2(MAX_VECTORS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic signed [31:0]     wr_data,
  input  logic                   start,
  input  logic [CW-1:0]          num_vectors,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [MAX_VECTORS-1:0] label_bits,
  output logic [CW-1:0]          pos_count,
  output logic signed [31:0]     test,
  output logic                   test_valid,
  input  logic                   test_ready,
  input  logic                   label,
  input  logic                   label_valid,
  output logic                   label_ready
);

  // state      | meaning
  // IDLE       | host may load buffer; waits for start
  // SEND       | presenting feature words of vector v
  // WAIT_LABEL | waiting for label of vector v; timeout timer runs
  // FINISH     | one-cycle wrap-up, raises done
  typedef enum logic [1:0] {IDLE, SEND, WAIT_LABEL, FINISH} state_t;

  localparam int IW = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                 state_q, state_d;
  logic signed [31:0]     mem_q [DEPTH];
  logic [AW-1:0]          addr_q, addr_d;
  logic [IW-1:0]          i_q, i_d;
  logic [CW-1:0]          v_q, v_d;
  logic [CW-1:0]          n_q, n_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [MAX_VECTORS-1:0] label_bits_q, label_bits_d;
  logic [CW-1:0]          pos_count_q, pos_count_d;
  logic signed [31:0]     test_q, test_d;
  logic                   test_valid_q, test_valid_d;
  logic                   label_ready_q, label_ready_d;
  logic [CW-1:0]          n_start;

  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE) mem_q[wr_addr] <= wr_data;
  end

  assign n_start = (num_vectors > CW'(MAX_VECTORS)) ? CW'(MAX_VECTORS) : num_vectors;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    i_d           = i_q;
    v_d           = v_q;
    n_d           = n_q;
    tmr_d         = tmr_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    label_bits_d  = label_bits_q;
    pos_count_d   = pos_count_q;
    test_d        = test_q;
    test_valid_d  = test_valid_q;
    label_ready_d = label_ready_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d          = n_start;
          done_d       = 1'b0;
          error_d      = 1'b0;
          label_bits_d = '0;
          pos_count_d  = '0;
          busy_d       = 1'b1;
          v_d          = '0;
          i_d          = '0;
          if (n_start == '0) begin
            state_d = FINISH;
          end else begin
            state_d      = SEND;
            test_d       = mem_q[0];
            test_valid_d = 1'b1;
            addr_d       = AW'(1);
          end
        end
      end
      SEND: begin
        if (test_ready) begin
          if (i_q == IW'(FEATURES - 1)) begin
            test_valid_d  = 1'b0;
            label_ready_d = 1'b1;
            tmr_d         = TW'(TIMEOUT - 1);
            state_d       = WAIT_LABEL;
          end else begin
            // addr_q always points at the word after the one on the bus
            i_d    = i_q + IW'(1);
            test_d = mem_q[addr_q];
            addr_d = addr_q + AW'(1);
          end
        end
      end
      WAIT_LABEL: begin
        if (label_valid) begin
          for (int k = 0; k < MAX_VECTORS; k++) begin
            if (v_q == CW'(k)) label_bits_d[k] = label;
          end
          pos_count_d   = pos_count_q + CW'(label);
          label_ready_d = 1'b0;
          if (v_q == n_q - CW'(1)) begin
            state_d = FINISH;
          end else begin
            v_d          = v_q + CW'(1);
            i_d          = '0;
            test_d       = mem_q[addr_q];
            addr_d       = addr_q + AW'(1);
            test_valid_d = 1'b1;
            state_d      = SEND;
          end
        end else if (tmr_q == '0) begin
          error_d       = 1'b1;
          busy_d        = 1'b0;
          label_ready_d = 1'b0;
          state_d       = IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      i_q           <= '0;
      v_q           <= '0;
      n_q           <= '0;
      tmr_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      label_bits_q  <= '0;
      pos_count_q   <= '0;
      test_q        <= '0;
      test_valid_q  <= 1'b0;
      label_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      i_q           <= i_d;
      v_q           <= v_d;
      n_q           <= n_d;
      tmr_q         <= tmr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      label_bits_q  <= label_bits_d;
      pos_count_q   <= pos_count_d;
      test_q        <= test_d;
      test_valid_q  <= test_valid_d;
      label_ready_q <= label_ready_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign label_bits  = label_bits_q;
  assign pos_count   = pos_count_q;
  assign test        = test_q;
  assign test_valid  = test_valid_q;
  assign label_ready = label_ready_q;

endmodule

// File: tb/tb_svm_batch_driver.sv
// Directed bench for svm_batch_driver: FEATURES=2, MAX_VECTORS=4, TIMEOUT=8,
// with hand-computed expected words, labels and flag timing.
module tb_svm_batch_driver;

  localparam int FEATURES    = 2;
  localparam int MAX_VECTORS = 4;
  localparam int TIMEOUT     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [2:0]        wr_addr = '0;
  logic signed [31:0] wr_data = '0;
  logic              start = 1'b0;
  logic [2:0]        num_vectors = '0;
  logic              busy, done, error;
  logic [3:0]        label_bits;
  logic [2:0]        pos_count;
  logic signed [31:0] test;
  logic              test_valid;
  logic              test_ready = 1'b0;
  logic              label = 1'b0;
  logic              label_valid = 1'b0;
  logic              label_ready;

  int n_vec  = 0;
  int n_miss = 0;

  svm_batch_driver #(
    .FEATURES(FEATURES), .MAX_VECTORS(MAX_VECTORS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .num_vectors(num_vectors), .busy(busy), .done(done),
    .error(error), .label_bits(label_bits), .pos_count(pos_count), .test(test),
    .test_valid(test_valid), .test_ready(test_ready), .label(label),
    .label_valid(label_valid), .label_ready(label_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge; outputs are then sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] n);
    start = 1'b1; num_vectors = n;
    tick();
    start = 1'b0;
  endtask

  // word must already be on the bus; hold it for 'stall' cycles, then accept it
  task automatic expect_word(input string tag, input logic [31:0] exp, input int stall);
    chk({tag, "_valid"}, {63'b0, test_valid}, 64'd1);
    chk({tag, "_data"}, {32'b0, test}, {32'b0, exp});
    for (int s = 0; s < stall; s++) begin
      test_ready = 1'b0;
      tick();
      chk({tag, "_hold"}, {31'b0, test_valid, test}, {31'b0, 1'b1, exp});
    end
    test_ready = 1'b1;
    tick();
    test_ready = 1'b0;
  endtask

  task automatic give_label(input string tag, input logic lbl, input int delay);
    chk({tag, "_lrdy"}, {62'b0, label_ready, test_valid}, 64'b10);
    for (int s = 0; s < delay; s++) tick();
    label_valid = 1'b1; label = lbl;
    tick();
    label_valid = 1'b0; label = 1'b0;
    chk({tag, "_lrdy_off"}, {63'b0, label_ready}, 64'd0);
  endtask

  // {busy, done, error, label_bits, pos_count}
  function automatic logic [63:0] flags();
    return {54'b0, busy, done, error, label_bits, pos_count};
  endfunction

  function automatic logic [63:0] f(input logic b, input logic d, input logic e,
                                     input logic [3:0] lb, input logic [2:0] pc);
    return {54'b0, b, d, e, lb, pc};
  endfunction

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("reset_flags", flags(), f(0, 0, 0, 4'b0, 3'd0));
    chk("reset_stream", {30'b0, test_valid, label_ready, test}, 64'd0);

    // single vector, label 1 two cycles after the last word handshake
    write_word(3'd0, 32'h0000a24e);
    write_word(3'd1, 32'h00000011);
    do_start(3'd1);
    chk("t1_busy", {63'b0, busy}, 64'd1);
    expect_word("t1_w0", 32'h0000a24e, 0);
    expect_word("t1_w1", 32'h00000011, 0);
    give_label("t1_lab", 1'b1, 1);
    chk("t1_finish", flags(), f(1, 0, 0, 4'b0001, 3'd1));
    tick();
    chk("t1_done", flags(), f(0, 1, 0, 4'b0001, 3'd1));

    // three vectors {1,2},{3,4},{-5,6} with stalls, labels 1,0,1
    write_word(3'd0, 32'd1);
    write_word(3'd1, 32'd2);
    write_word(3'd2, 32'd3);
    write_word(3'd3, 32'd4);
    write_word(3'd4, 32'hFFFFFFFB);
    write_word(3'd5, 32'd6);
    write_word(3'd6, 32'd7);
    write_word(3'd7, 32'd8);
    do_start(3'd3);
    chk("t2_start_clr", flags(), f(1, 0, 0, 4'b0, 3'd0));
    expect_word("t2_w0", 32'd1, 0);
    expect_word("t2_w1", 32'd2, 1);
    give_label("t2_l0", 1'b1, 0);
    expect_word("t2_w2", 32'd3, 1);
    expect_word("t2_w3", 32'd4, 0);
    give_label("t2_l1", 1'b0, 2);
    expect_word("t2_w4", 32'hFFFFFFFB, 0);
    expect_word("t2_w5", 32'd6, 1);
    give_label("t2_l2", 1'b1, 0);
    tick();
    chk("t2_done", flags(), f(0, 1, 0, 4'b0101, 3'd2));

    // empty batch
    do_start(3'd0);
    chk("t3_busy", flags(), f(1, 0, 0, 4'b0, 3'd0));
    chk("t3_novalid", {63'b0, test_valid}, 64'd0);
    tick();
    chk("t3_done", flags(), f(0, 1, 0, 4'b0, 3'd0));

    // label of vector 0 arrives, vector 1 times out
    do_start(3'd2);
    expect_word("t4_w0", 32'd1, 0);
    expect_word("t4_w1", 32'd2, 0);
    give_label("t4_l0", 1'b1, 0);
    expect_word("t4_w2", 32'd3, 0);
    expect_word("t4_w3", 32'd4, 0);
    chk("t4_lrdy", {63'b0, label_ready}, 64'd1);
    for (int c = 0; c < TIMEOUT - 1; c++) tick();
    chk("t4_pre_to", flags(), f(1, 0, 0, 4'b0001, 3'd1));
    tick();
    chk("t4_timeout", flags(), f(0, 0, 1, 4'b0001, 3'd1));
    chk("t4_lrdy_off", {63'b0, label_ready}, 64'd0);
    label_valid = 1'b1; label = 1'b1;
    tick();
    chk("t4_idle_lab", {63'b0, label_ready}, 64'd0);
    chk("t4_idle_flags", flags(), f(0, 0, 1, 4'b0001, 3'd1));
    label_valid = 1'b0; label = 1'b0;

    // reset mid-SEND, then a clean batch
    do_start(3'd2);
    chk("t5_send", {63'b0, test_valid}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_flags", flags(), f(0, 0, 0, 4'b0, 3'd0));
    chk("t5_rst_stream", {30'b0, test_valid, label_ready, test}, 64'd0);
    do_start(3'd1);
    expect_word("t5_w0", 32'd1, 0);
    expect_word("t5_w1", 32'd2, 0);
    give_label("t5_l0", 1'b0, 0);
    tick();
    chk("t5_done", flags(), f(0, 1, 0, 4'b0000, 3'd0));

    // start and write while busy are ignored
    do_start(3'd1);
    start = 1'b1; num_vectors = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h0000dead;
    tick();
    start = 1'b0; wr_en = 1'b0;
    expect_word("t6_w0", 32'd1, 0);
    expect_word("t6_w1", 32'd2, 0);
    give_label("t6_l0", 1'b1, 0);
    tick();
    chk("t6_done", flags(), f(0, 1, 0, 4'b0001, 3'd1));

    // num_vectors above MAX_VECTORS clamps; buffer still holds original data
    do_start(3'd6);
    expect_word("t7_w0", 32'd1, 0);
    expect_word("t7_w1", 32'd2, 0);
    give_label("t7_l0", 1'b1, 0);
    expect_word("t7_w2", 32'd3, 0);
    expect_word("t7_w3", 32'd4, 0);
    give_label("t7_l1", 1'b1, 0);
    expect_word("t7_w4", 32'hFFFFFFFB, 0);
    expect_word("t7_w5", 32'd6, 0);
    give_label("t7_l2", 1'b1, 0);
    expect_word("t7_w6", 32'd7, 0);
    expect_word("t7_w7", 32'd8, 0);
    give_label("t7_l3", 1'b1, 0);
    // now in FINISH: a start here is ignored, accepted one cycle later
    start = 1'b1; num_vectors = 3'd0;
    tick();
    chk("t7_done", flags(), f(0, 1, 0, 4'b1111, 3'd4));
    tick();
    start = 1'b0;
    chk("t7_restart", flags(), f(1, 0, 0, 4'b0000, 3'd0));
    tick();
    chk("t7_redone", flags(), f(0, 1, 0, 4'b0000, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
